axil_regfile_shadowed: RTL and testbench

- Parametrised AXI4-Lite slave register bank; successor to the fixed 4-register HDMI text controller slave.
- Adds: configurable register count, byte strobes, read-only status registers, and SLVERR on illegal access.
- Adds an optional vsync-synchronised shadow mode, so the video engine never sees a half-updated register set mid-frame.
- Sits between the AXI interconnect and the HDMI text/video logic.

---
 rtl/axil_regfile_shadowed.sv | 127 ++++++++++++
 tb/tb_axil_regfile_shadowed.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile_shadowed.sv
// axil_regfile_shadowed: AXI4-Lite register bank with byte strobes, RO status regs, SLVERR and optional vsync shadowing
module axil_regfile_shadowed #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter bit SHADOW = 1'b0
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDR_WIDTH-1:0]    AWADDR,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ADDR_WIDTH-1:0]    ARADDR,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic [NUM_REGS*32-1:0]   status_i,
  input  logic                     vsync_i,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);
  localparam int IW = ADDR_WIDTH - 2;
  logic aw_held, w_held, vsync_prev, commit, wr_ok, vs_rise, unused_lsb;
  logic [IW-1:0] aw_idx;
  logic [31:0] w_data, rd_data;
  logic [3:0] w_strb;
  logic [NUM_REGS-1:0] wr_hit, ar_hit;
  logic [31:0] active [NUM_REGS];
  logic [31:0] shadow [NUM_REGS];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  assign AWREADY = !ARESET && !aw_held && !BVALID;
  assign WREADY = !ARESET && !w_held && !BVALID;
  assign ARREADY = !ARESET && !RVALID;
  assign commit = aw_held && w_held;
  assign vs_rise = SHADOW && vsync_i && !vsync_prev;
  assign wr_ok = |(wr_hit & ~RO_MASK);
  assign unused_lsb = ^{AWADDR[1:0], ARADDR[1:0]};

  // address decode, software-view read mux and hardware-view register outputs
  always_comb begin
    rd_data = '0;
    wr_hit = '0;
    ar_hit = '0;
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = aw_idx == IW'(i);
      ar_hit[i] = ARADDR[ADDR_WIDTH-1:2] == IW'(i);
      if (ar_hit[i]) rd_data = RO_MASK[i] ? status_i[32*i +: 32] : SHADOW ? shadow[i] : active[i];
      regs_o[32*i +: 32] = RO_MASK[i] ? status_i[32*i +: 32] : active[i];
    end
  end

  // channel handshakes, write commit with response/pulse, and read response
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      BVALID <= 1'b0;
      BRESP <= '0;
      RVALID <= 1'b0;
      RRESP <= '0;
      RDATA <= '0;
      wr_pulse_o <= '0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync_i;
      wr_pulse_o <= '0;
      if (AWVALID && AWREADY) begin
        aw_held <= 1'b1;
        aw_idx <= AWADDR[ADDR_WIDTH-1:2];
      end
      if (WVALID && WREADY) begin
        w_held <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        BVALID <= 1'b1;
        BRESP <= wr_ok ? 2'b00 : 2'b10;
        wr_pulse_o <= wr_hit & ~RO_MASK;
      end
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RDATA <= rd_data;
        RRESP <= |ar_hit ? 2'b00 : 2'b10;
      end else if (RVALID && RREADY) RVALID <= 1'b0;
    end

  // storage: commits land in shadow (or active when unshadowed); a vsync rise copies pre-commit shadow to active
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (vs_rise) active[i] <= shadow[i];
        if (commit && wr_hit[i] && !RO_MASK[i]) begin
          if (SHADOW) shadow[i] <= merge(shadow[i], w_data, w_strb);
          else active[i] <= merge(active[i], w_data, w_strb);
        end
      end
    end
endmodule

// File: tb/tb_axil_regfile_shadowed.sv
// tb_axil_regfile_shadowed: directed checks of an unshadowed bank and a shadowed bank with one RO status register
module tb_axil_regfile_shadowed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][7:0] awaddr, araddr;
  logic [1:0] awvalid, wvalid, bready, arvalid, rready, vs;
  logic [1:0] awready, wready, bvalid, arready, rvalid;
  logic [1:0][31:0] wdata, rdata;
  logic [1:0][3:0] wstrb;
  logic [1:0][1:0] bresp, rresp;
  logic [1:0][511:0] st, regs;
  logic [1:0][15:0] pulse;
  int checks = 0, failures = 0, pc0 = 0, pc1 = 0;

  axil_regfile_shadowed #(.NUM_REGS(16), .ADDR_WIDTH(8), .RO_MASK(16'h0000), .SHADOW(1'b0)) dut0 (
    .ACLK(clk), .ARESET(rst),
    .AWADDR(awaddr[0]), .AWVALID(awvalid[0]), .AWREADY(awready[0]),
    .WDATA(wdata[0]), .WSTRB(wstrb[0]), .WVALID(wvalid[0]), .WREADY(wready[0]),
    .BRESP(bresp[0]), .BVALID(bvalid[0]), .BREADY(bready[0]),
    .ARADDR(araddr[0]), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
    .RDATA(rdata[0]), .RRESP(rresp[0]), .RVALID(rvalid[0]), .RREADY(rready[0]),
    .status_i(st[0]), .vsync_i(vs[0]), .regs_o(regs[0]), .wr_pulse_o(pulse[0]));

  axil_regfile_shadowed #(.NUM_REGS(16), .ADDR_WIDTH(8), .RO_MASK(16'h0008), .SHADOW(1'b1)) dut1 (
    .ACLK(clk), .ARESET(rst),
    .AWADDR(awaddr[1]), .AWVALID(awvalid[1]), .AWREADY(awready[1]),
    .WDATA(wdata[1]), .WSTRB(wstrb[1]), .WVALID(wvalid[1]), .WREADY(wready[1]),
    .BRESP(bresp[1]), .BVALID(bvalid[1]), .BREADY(bready[1]),
    .ARADDR(araddr[1]), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
    .RDATA(rdata[1]), .RRESP(rresp[1]), .RVALID(rvalid[1]), .RREADY(rready[1]),
    .status_i(st[1]), .vsync_i(vs[1]), .regs_o(regs[1]), .wr_pulse_o(pulse[1]));

  always @(negedge clk) begin
    pc0 <= pc0 + $countones(pulse[0]);
    pc1 <= pc1 + $countones(pulse[1]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b, output logic [1:0] resp);
    bit ah, wh, done;
    awaddr[s] = a; wdata[s] = d; wstrb[s] = b;
    awvalid[s] = 1'b1; wvalid[s] = 1'b1; bready[s] = 1'b1;
    resp = 2'bxx; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      ah = awvalid[s] && awready[s];
      wh = wvalid[s] && wready[s];
      if (bvalid[s]) begin resp = bresp[s]; done = 1'b1; end
      step;
      if (ah) awvalid[s] = 1'b0;
      if (wh) wvalid[s] = 1'b0;
    end
    awvalid[s] = 1'b0; wvalid[s] = 1'b0;
    chk("wr_done", {31'b0, done}, 32'd1);
  endtask

  task automatic rd(input int s, input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ah, done;
    araddr[s] = a; arvalid[s] = 1'b1; rready[s] = 1'b1;
    d = 'x; resp = 2'bxx; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      ah = arvalid[s] && arready[s];
      if (rvalid[s]) begin d = rdata[s]; resp = rresp[s]; done = 1'b1; end
      step;
      if (ah) arvalid[s] = 1'b0;
    end
    arvalid[s] = 1'b0;
    chk("rd_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    logic [1:0] r;
    logic [31:0] d;
    int p;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0; vs = '0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; st = '0;
    st[1][96 +: 32] = 32'hDEADBEEF;
    repeat (3) step;
    chk("rst_awready", {31'b0, awready[0]}, 0);
    chk("rst_wready", {31'b0, wready[0]}, 0);
    chk("rst_arready", {31'b0, arready[0]}, 0);
    rst = 1'b0;
    step;
    chk("rst_bvalid", {30'b0, bvalid}, 0);
    chk("rst_rvalid", {30'b0, rvalid}, 0);
    chk("rst_regs0", {31'b0, |regs[0]}, 0);
    chk("rst_regs1_r0", regs[1][31:0], 0);
    chk("rst_pulse", {pulse[1], pulse[0]}, 0);
    chk("rst_awready_rel", {31'b0, awready[0]}, 1);
    // basic writes and readback
    p = pc0;
    for (int i = 0; i < 4; i++) begin
      wr(0, 8'(4 * i), 32'(i + 1), 4'hF, r);
      chk("wr_bresp", {30'b0, r}, 0);
    end
    chk("wr_pulses4", pc0, p + 4);
    chk("regs_o_r2", regs[0][64 +: 32], 32'h3);
    for (int i = 0; i < 4; i++) begin
      rd(0, 8'(4 * i), d, r);
      chk("rd_data", d, 32'(i + 1));
      chk("rd_rresp", {30'b0, r}, 0);
    end
    // byte strobes
    wr(0, 8'h08, 32'hAABBCCDD, 4'hF, r);
    wr(0, 8'h08, 32'h11223344, 4'h5, r);
    rd(0, 8'h08, d, r);
    chk("wstrb_merge", d, 32'hAA22CC44);
    p = pc0;
    wr(0, 8'h08, 32'hFFFFFFFF, 4'h0, r);
    chk("wstrb0_bresp", {30'b0, r}, 0);
    chk("wstrb0_pulse", pc0, p + 1);
    rd(0, 8'h08, d, r);
    chk("wstrb0_data", d, 32'hAA22CC44);
    // W three cycles ahead of AW, BREADY held low
    bready[0] = 1'b0; wdata[0] = 32'h00000055; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    step;
    wvalid[0] = 1'b0;
    chk("w_held_wready", {31'b0, wready[0]}, 0);
    step;
    step;
    awaddr[0] = 8'h14; awvalid[0] = 1'b1;
    step;
    awvalid[0] = 1'b0;
    chk("bvalid_at_aw", {31'b0, bvalid[0]}, 0);
    step;
    chk("bvalid_aw_plus1", {31'b0, bvalid[0]}, 1);
    chk("order_bresp", {30'b0, bresp[0]}, 0);
    chk("order_regs_r5", regs[0][160 +: 32], 32'h55);
    for (int n = 0; n < 5; n++) begin
      chk("bhold_awready", {31'b0, awready[0]}, 0);
      chk("bhold_wready", {31'b0, wready[0]}, 0);
      chk("bhold_bvalid", {31'b0, bvalid[0]}, 1);
      step;
    end
    bready[0] = 1'b1;
    step;
    chk("bvalid_cleared", {31'b0, bvalid[0]}, 0);
    rd(0, 8'h40, d, r);
    chk("oor_rd_data0", d, 0);
    chk("oor_rd_resp0", {30'b0, r}, 2);
    // errors and RO status
    p = pc1;
    wr(1, 8'h0C, 32'h00000001, 4'hF, r);
    chk("ro_wr_bresp", {30'b0, r}, 2);
    chk("ro_wr_nopulse", pc1, p);
    chk("ro_regs_o", regs[1][96 +: 32], 32'hDEADBEEF);
    st[1][96 +: 32] = 32'h01234567;
    #1;
    chk("ro_regs_follow", regs[1][96 +: 32], 32'h01234567);
    rd(1, 8'h0C, d, r);
    chk("ro_rd_data", d, 32'h01234567);
    chk("ro_rd_resp", {30'b0, r}, 0);
    rd(1, 8'h40, d, r);
    chk("oor_rd_data", d, 0);
    chk("oor_rd_resp", {30'b0, r}, 2);
    wr(1, 8'h40, 32'h5A5A5A5A, 4'hF, r);
    chk("oor_wr_bresp", {30'b0, r}, 2);
    // shadow mode
    wr(1, 8'h00, 32'h12345678, 4'hF, r);
    chk("sh_bresp", {30'b0, r}, 0);
    rd(1, 8'h00, d, r);
    chk("sh_rd_shadow", d, 32'h12345678);
    chk("sh_active_old", regs[1][31:0], 0);
    vs[1] = 1'b1;
    step;
    chk("sh_vsync_copy", regs[1][31:0], 32'h12345678);
    vs[1] = 1'b0;
    step;
    step;
    awaddr[1] = 8'h00; wdata[1] = 32'hCAFEF00D; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1; bready[1] = 1'b1;
    step;
    awvalid[1] = 1'b0; wvalid[1] = 1'b0; vs[1] = 1'b1;
    step;
    chk("same_edge_commit", {31'b0, bvalid[1]}, 1);
    chk("same_edge_active", regs[1][31:0], 32'h12345678);
    step;
    chk("same_edge_bclr", {31'b0, bvalid[1]}, 0);
    rd(1, 8'h00, d, r);
    chk("same_edge_shadow", d, 32'hCAFEF00D);
    chk("same_edge_hold", regs[1][31:0], 32'h12345678);
    vs[1] = 1'b0;
    step;
    vs[1] = 1'b1;
    step;
    chk("next_rise_copy", regs[1][31:0], 32'hCAFEF00D);
    vs[1] = 1'b0;
    // reset with AW held and W pending
    awaddr[0] = 8'h18; awvalid[0] = 1'b1; bready[0] = 1'b1;
    step;
    awvalid[0] = 1'b0; wdata[0] = 32'h00000099; wvalid[0] = 1'b1;
    #1 rst = 1'b1;
    #1 wvalid[0] = 1'b0;
    step;
    step;
    rst = 1'b0;
    step;
    step;
    chk("mid_rst_bvalid", {31'b0, bvalid[0]}, 0);
    chk("mid_rst_r6", regs[0][192 +: 32], 0);
    chk("mid_rst_regs", {31'b0, |regs[0]}, 0);
    chk("mid_rst_awready", {31'b0, awready[0]}, 1);
    chk("mid_rst_wready", {31'b0, wready[0]}, 1);
    p = pc0;
    wr(0, 8'h18, 32'h00000066, 4'hF, r);
    chk("fresh_bresp", {30'b0, r}, 0);
    chk("fresh_pulse", pc0, p + 1);
    rd(0, 8'h18, d, r);
    chk("fresh_rd", d, 32'h66);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
